control_multiciclo: RTL and testbench

- Multicycle RISC-V main control FSM plus ALU decoder.
- Drives every datapath select, including the 2-bit select of the 3-input result multiplexer that feeds the register file and PC.
- Sits directly upstream of that multiplexer. Consumes the instruction register fields and the ALU zero flag.
- Supports lw, sw, R-type, I-type ALU, jal and beq.

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/control_multiciclo.sv | 144 ++++++++++++++
 tb/tb_control_multiciclo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes and every datapath select code driven by the controller.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } stateT;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // Result mux inputs are wired in the order ALUOut, Data, ALUResult.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's coarse aluOp plus the
// instruction function fields into the ALU operation select.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] aluControl
);

  // Only R-type sets op[5], so addi with instr[30]=1 stays an add.
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  aluControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RISC-V main controller: state register, Moore output decode,
// immediate-format decode and the ALU decoder instance.
module control_multiciclo
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write
);

  if (XLEN != 32 && XLEN != 64) begin : gXlenUnsupported
    $error("control_multiciclo: XLEN must be 32 or 64");
  end

  stateT      state;
  logic       pcUpdate;
  logic       branch;
  logic [1:0] aluOp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_JAL:       state <= JAL;
            OP_BEQ:       state <= BEQ;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        JAL:      state <= ALUWB;
        BEQ:      state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    aluOp      = ALUOP_ADD;
    reg_write  = 1'b0;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pcUpdate   = 1'b1;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RS1;
        aluOp     = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluOp     = ALUOP_FUNCT;
      end
      ALUWB: reg_write = 1'b1;
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pcUpdate  = 1'b1;
      end
      BEQ: begin
        alu_src_a = SRCA_RS1;
        aluOp     = ALUOP_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write = pcUpdate | (branch & zero);

  // Immediate format follows the opcode alone so the extender is ready early.
  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder uAluDecoder (
    .aluOp      (aluOp),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opb5       (op[5]),
    .aluControl (alu_control)
  );

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: walks each instruction class through
// its states and compares the full control word against hand-written values.
module tb_control_multiciclo;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;
  logic [15:0] ctrlWord;

  int checks   = 0;
  int failures = 0;

  control_multiciclo dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: pcW adr memW irW | res[2] srcA[2] srcB[2] imm[2] alu[3] regW
  assign ctrlWord = {pc_write, adr_src, mem_write, ir_write, result_src,
                     alu_src_a, alu_src_b, imm_src, alu_control, reg_write};

  function automatic logic [15:0] mk(input logic pcW, input logic adr,
                                     input logic memW, input logic irW,
                                     input logic [1:0] res, input logic [1:0] srcA,
                                     input logic [1:0] srcB, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic regW);
    return {pcW, adr, memW, irW, res, srcA, srcB, imm, alu, regW};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] opIn, input logic [2:0] f3,
                               input logic f7b5, input logic zeroIn);
    op       = opIn;
    funct3   = f3;
    funct7b5 = f7b5;
    zero     = zeroIn;
  endtask

  task automatic stepCheck(input string tag, input logic [15:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, ctrlWord, expected);
  endtask

  // FETCH and DECODE words only vary with the opcode's immediate format.
  function automatic logic [15:0] fetchW(input logic [1:0] imm);
    return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endfunction

  function automatic logic [15:0] decodeW(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
  endfunction

  logic [2:0] rF3  [4] = '{3'b000, 3'b110, 3'b111, 3'b010};
  logic       rF7  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] rAlu [4] = '{3'b000, 3'b011, 3'b010, 3'b101};

  initial begin
    rst = 1'b1;
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset.fetch", ctrlWord, fetchW(2'b00));

    // lw: FETCH DECODE MEMADR MEMREAD MEMWB
    stepCheck("lw.decode",  decodeW(2'b00));
    stepCheck("lw.memadr",  mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    stepCheck("lw.memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    stepCheck("lw.memwb",   mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1));

    // sw
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
    stepCheck("sw.fetch",    fetchW(2'b01));
    stepCheck("sw.decode",   decodeW(2'b01));
    stepCheck("sw.memadr",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    stepCheck("sw.memwrite", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));

    // R-type sub
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
    stepCheck("sub.fetch",    fetchW(2'b00));
    stepCheck("sub.decode",   decodeW(2'b00));
    stepCheck("sub.executer", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
    stepCheck("sub.aluwb",    mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));

    // addi with instr[30]=1 must remain add
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0);
    stepCheck("addi.fetch",    fetchW(2'b00));
    stepCheck("addi.decode",   decodeW(2'b00));
    stepCheck("addi.executei", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    stepCheck("addi.aluwb",    mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));

    // Other R-type functions: add, or, and, slt
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'b0110011, rF3[i], rF7[i], 1'b0);
      stepCheck($sformatf("r%0d.fetch", i), fetchW(2'b00));
      stepCheck($sformatf("r%0d.decode", i), decodeW(2'b00));
      stepCheck($sformatf("r%0d.executer", i),
                mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, rAlu[i], 0));
      stepCheck($sformatf("r%0d.aluwb", i),
                mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    end

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      applyStimulus(7'b1100011, 3'b000, 1'b0, z[0]);
      stepCheck($sformatf("beq%0d.fetch", z), fetchW(2'b10));
      stepCheck($sformatf("beq%0d.decode", z), decodeW(2'b10));
      stepCheck($sformatf("beq%0d.beq", z),
                mk(z[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
    end

    // jal
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
    stepCheck("jal.fetch",  fetchW(2'b11));
    stepCheck("jal.decode", decodeW(2'b11));
    stepCheck("jal.jal",    mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
    stepCheck("jal.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1));

    // lw interrupted by reset in MEMREAD
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
    stepCheck("lwrst.fetch",   fetchW(2'b00));
    stepCheck("lwrst.decode",  decodeW(2'b00));
    stepCheck("lwrst.memadr",  mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    stepCheck("lwrst.memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    rst = 1'b1;
    stepCheck("lwrst.fetch2",  fetchW(2'b00));
    rst = 1'b0;

    // Unsupported lui opcode behaves as a nop
    applyStimulus(7'b0110111, 3'b000, 1'b0, 1'b1);
    stepCheck("nop.decode", decodeW(2'b00));
    stepCheck("nop.fetch",  fetchW(2'b00));
    stepCheck("nop.decode2", decodeW(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
